producer_fifo: RTL and testbench

- Upstream stage feeding the 4-bit data consumer.
- Buffers 4-bit words written by a local source into a DEPTH-entry FIFO.
- Serves one word per consumer request pulse: pops the FIFO and presents the word on producer_data with a one-cycle valid strobe.
- Fully synchronous to the consumer-side clock.

---
 rtl/producer_fifo.sv | 185 ++++++++++++++++++
 tb/tb_producer_fifo.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/producer_fifo.sv
// ---------------------------------------------------------------------------
// producer_fifo
//
// Upstream stage for the 4-bit data consumer. A local source writes 4-bit
// words into a DEPTH-entry FIFO. Each rising edge of the consumer's request
// pops one word onto producer_data, together with a one-cycle
// producer_valid strobe. If a request arrives while the FIFO is empty, it
// is held in the PEND state until a word is available.
//
// Optional build macro:
//   PRODUCER_REQ_QUEUE_EN
//     Adds a 2-bit saturating counter of request edges seen in the PEND or
//     SEND states. Each counted edge is served later. When the macro is not
//     defined, those edges are dropped.
//
// Ports:
//   producer_iclk      in   clock; all state changes on the rising edge
//   producer_irst      in   synchronous active-high reset
//   producer_wr_en     in   source write strobe
//   producer_wr_data   in   [3:0] source write word
//   producer_req       in   consumer request level; a rising edge is one request
//   producer_data      out  [3:0] last popped word
//   producer_valid     out  one-cycle strobe; producer_data is new this cycle
//   producer_full      out  occupancy == DEPTH
//   producer_empty     out  occupancy == 0
//   producer_count     out  [ADDR_W:0] current occupancy
//   producer_ovf       out  sticky flag; set when a write hits a full FIFO
// ---------------------------------------------------------------------------
module producer_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              producer_iclk,
  input  logic              producer_irst,
  input  logic              producer_wr_en,
  input  logic [3:0]        producer_wr_data,
  input  logic              producer_req,
  output logic [3:0]        producer_data,
  output logic              producer_valid,
  output logic              producer_full,
  output logic              producer_empty,
  output logic [ADDR_W:0]   producer_count,
  output logic              producer_ovf
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, PEND, SEND} state_t;

  logic [3:0]        mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_reg;
  logic [ADDR_W-1:0] rd_ptr_reg;
  logic [ADDR_W:0]   count_reg;
  logic [ADDR_W:0]   count_next;
  state_t            state_reg;
  logic              req_d_reg;
  logic [3:0]        data_reg;
  logic              valid_reg;
  logic              ovf_reg;

  logic req_edge;
  logic wr_accept;
  logic overflow_hit;
  logic pop;

`ifdef PRODUCER_REQ_QUEUE_EN
  logic [1:0] pending_reg;
  logic [1:0] pending_next;
  logic       pending_inc;
  logic       pending_dec;
`endif

  // Pop eligibility looks only at the registered count. A word written in
  // the same cycle is therefore never forwarded straight to the output.
  always_comb begin
    req_edge     = producer_req & ~req_d_reg;
    wr_accept    = producer_wr_en && (count_reg != DEPTH_C);
    overflow_hit = producer_wr_en && (count_reg == DEPTH_C);
    pop          = 1'b0;
    case (state_reg)
      IDLE:    pop = req_edge && (count_reg != '0);
      PEND:    pop = (count_reg != '0);
      default: pop = 1'b0;
    endcase

    count_next = count_reg;
    case ({wr_accept, pop})
      2'b10:   count_next = count_reg + (ADDR_W+1)'(1);
      2'b01:   count_next = count_reg - (ADDR_W+1)'(1);
      default: count_next = count_reg;
    endcase
  end

`ifdef PRODUCER_REQ_QUEUE_EN
  // Count request edges that arrive while a request is already being
  // handled. A simultaneous increment and decrement leave the count
  // unchanged. The counter saturates at 3.
  always_comb begin
    pending_inc  = req_edge && ((state_reg == PEND) || (state_reg == SEND));
    pending_dec  = (state_reg == SEND) && (pending_reg != 2'd0);
    pending_next = pending_reg;
    if (pending_inc && !pending_dec && (pending_reg != 2'd3))
      pending_next = pending_reg + 2'd1;
    else if (pending_dec && !pending_inc)
      pending_next = pending_reg - 2'd1;
  end
`endif

  // Storage array with no reset, so it can map onto block RAM.
  always_ff @(posedge producer_iclk) begin
    if (wr_accept)
      mem[wr_ptr_reg] <= producer_wr_data;
  end

  always_ff @(posedge producer_iclk) begin
    if (producer_irst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
      state_reg   <= IDLE;
      req_d_reg   <= 1'b0;
      data_reg    <= 4'b0000;
      valid_reg   <= 1'b0;
      ovf_reg     <= 1'b0;
`ifdef PRODUCER_REQ_QUEUE_EN
      pending_reg <= 2'd0;
`endif
    end else begin
      req_d_reg <= producer_req;
      count_reg <= count_next;

      if (wr_accept)
        wr_ptr_reg <= wr_ptr_reg + ADDR_W'(1);
      if (overflow_hit)
        ovf_reg <= 1'b1;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + ADDR_W'(1);
        data_reg   <= mem[rd_ptr_reg];
      end

      case (state_reg)
        IDLE: begin
          if (pop) begin
            valid_reg <= 1'b1;
            state_reg <= SEND;
          end else if (req_edge) begin
            state_reg <= PEND;
          end
        end
        PEND: begin
          if (pop) begin
            valid_reg <= 1'b1;
            state_reg <= SEND;
          end
        end
        SEND: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
`ifdef PRODUCER_REQ_QUEUE_EN
          // A queued request re-enters PEND. PEND pops on the next edge if
          // data is present. This gap keeps the valid strobe to one cycle.
          if (pending_reg != 2'd0)
            state_reg <= PEND;
`endif
        end
        default: begin
          valid_reg <= 1'b0;
          state_reg <= IDLE;
        end
      endcase

`ifdef PRODUCER_REQ_QUEUE_EN
      pending_reg <= pending_next;
`endif
    end
  end

  assign producer_data  = data_reg;
  assign producer_valid = valid_reg;
  assign producer_full  = (count_reg == DEPTH_C);
  assign producer_empty = (count_reg == '0);
  assign producer_count = count_reg;
  assign producer_ovf   = ovf_reg;

endmodule

// File: tb/tb_producer_fifo.sv
// ---------------------------------------------------------------------------
// tb_producer_fifo
//
// Directed testbench for producer_fifo, checked against a scoreboard.
// The stimulus pushes each expected popped word into exp_q. A separate
// monitor compares producer_data against the front of the queue on every
// valid strobe. Flag and count checks are made inline, #1 after the edge.
// ---------------------------------------------------------------------------
module tb_producer_fifo;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              srst;
  logic              wr_en;
  logic [3:0]        wr_data;
  logic              req;
  logic [3:0]        data;
  logic              valid;
  logic              full;
  logic              empty;
  logic [ADDR_W:0]   count;
  logic              ovf;

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [$];
  logic prev_valid = 1'b0;

  producer_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .producer_iclk    (clk),
    .producer_irst    (srst),
    .producer_wr_en   (wr_en),
    .producer_wr_data (wr_data),
    .producer_req     (req),
    .producer_data    (data),
    .producer_valid   (valid),
    .producer_full    (full),
    .producer_empty   (empty),
    .producer_count   (count),
    .producer_ovf     (ovf)
  );

  always #5 clk = ~clk;

  // Monitor: one line per popped word, compared against the scoreboard.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      checks++;
      if (prev_valid === 1'b1) begin
        errors++;
        $display("FAIL valid_pulse: valid high two cycles in a row, required single-cycle strobe");
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pop: data=%h with no expected word queued", data);
      end else begin
        logic [3:0] exp_w;
        exp_w = exp_q.pop_front();
        if (data !== exp_w) begin
          errors++;
          $display("FAIL pop_data: got %h required %h", data, exp_w);
        end else begin
          $display("pop data=%h ok", data);
        end
      end
    end
    prev_valid = valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp_v);
    end else begin
      $display("check %s = %0h ok", name, act);
    end
  endtask

  task automatic write_word(input logic [3:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic req_pulse(input logic [3:0] exp_w);
    exp_q.push_back(exp_w);
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
  endtask

  // Wait a bounded number of cycles for the scoreboard to empty.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s: %0d expected words never popped, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    srst    = 1'b1;
    wr_en   = 1'b0;
    wr_data = 4'h0;
    req     = 1'b0;
    tick();
    tick();
    srst = 1'b0;
    check("rst_data",  8'(data),  8'h0);
    check("rst_valid", 8'(valid), 8'h0);
    check("rst_empty", 8'(empty), 8'h1);
    check("rst_full",  8'(full),  8'h0);
    check("rst_ovf",   8'(ovf),   8'h0);
    check("rst_count", 8'(count), 8'h0);

    // Basic write/read with a one-cycle latency check.
    write_word(4'hA);
    write_word(4'h5);
    check("two_count", 8'(count), 8'h2);
    exp_q.push_back(4'hA);
    req = 1'b1;
    tick();
    check("latency_valid", 8'(valid), 8'h1);
    req = 1'b0;
    tick();
    req_pulse(4'h5);
    drain("basic_drain");
    check("basic_empty", 8'(empty), 8'h1);

    // A request while empty waits in PEND until a word arrives.
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    tick();
    tick();
    exp_q.push_back(4'h3);
    write_word(4'h3);
    check("pend_count1", 8'(count), 8'h1);
    check("pend_no_bypass", 8'(valid), 8'h0);
    tick();
    check("pend_valid", 8'(valid), 8'h1);
    tick();
    drain("pend_drain");

    // Overfill, then read back in order across the pointer wrap.
    for (int i = 0; i <= DEPTH; i++) write_word(4'(i));
    check("ovf_full",  8'(full),  8'h1);
    check("ovf_count", 8'(count), 8'h8);
    check("ovf_flag",  8'(ovf),   8'h1);
    check("ovf_empty", 8'(empty), 8'h0);
    for (int i = 0; i < DEPTH; i++) req_pulse(4'(i));
    drain("wrap_drain");
    check("wrap_empty", 8'(empty), 8'h1);
    check("ovf_sticky", 8'(ovf),   8'h1);

    // A simultaneous write and pop at count=4 leaves the count unchanged.
    write_word(4'hB);
    write_word(4'hC);
    write_word(4'hD);
    write_word(4'hE);
    check("sim_count_pre", 8'(count), 8'h4);
    exp_q.push_back(4'hB);
    req     = 1'b1;
    wr_en   = 1'b1;
    wr_data = 4'hF;
    tick();
    req   = 1'b0;
    wr_en = 1'b0;
    check("sim_count_post", 8'(count), 8'h4);
    check("sim_valid", 8'(valid), 8'h1);
    tick();
    req_pulse(4'hC);
    req_pulse(4'hD);
    req_pulse(4'hE);
    req_pulse(4'hF);
    drain("sim_drain");
    check("sim_empty", 8'(empty), 8'h1);

    // Holding the request high for 5 cycles gives exactly one pop.
    write_word(4'h1);
    write_word(4'h2);
    exp_q.push_back(4'h1);
    req = 1'b1;
    repeat (5) tick();
    req = 1'b0;
    tick();
    tick();
    check("hold_count", 8'(count), 8'h1);
    drain("hold_drain");
    req_pulse(4'h2);
    drain("hold_drain2");

    // A reset while in PEND discards the pending request.
    req = 1'b1;
    tick();
    req = 1'b0;
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    check("prst_data",  8'(data),  8'h0);
    check("prst_valid", 8'(valid), 8'h0);
    check("prst_count", 8'(count), 8'h0);
    check("prst_ovf",   8'(ovf),   8'h0);
    write_word(4'h7);
    repeat (4) tick();
    check("prst_no_pop", 8'(count), 8'h1);
    req_pulse(4'h7);
    drain("prst_drain");

    // Request edges that arrive while already in PEND.
    for (int k = 0; k < 4; k++) begin
      req = 1'b1;
      tick();
      req = 1'b0;
      tick();
    end
    exp_q.push_back(4'h9);
`ifdef PRODUCER_REQ_QUEUE_EN
    exp_q.push_back(4'hA);
    exp_q.push_back(4'hB);
    exp_q.push_back(4'hC);
`endif
    write_word(4'h9);
    write_word(4'hA);
    write_word(4'hB);
    write_word(4'hC);
    repeat (20) tick();
    drain("queue_drain");
`ifdef PRODUCER_REQ_QUEUE_EN
    check("queue_count", 8'(count), 8'h0);
`else
    check("queue_count", 8'(count), 8'h3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
